// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding and the
// idle levels that the input synchronisers come out of reset with.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LEAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Line levels seen while no frame is in progress.
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus one extra flop so
// single-cycle rise/fall strobes can be derived from the synchronised level.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain; reset forces the line's idle level so no edge is
  // reported when reset is released on an idle bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/chip_select/mosi on the system clock,
// shifts a held transmit byte out on miso and assembles the received byte,
// reporting completion with rx_valid or an early chip_select release with
// frame_abort.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEAD_EDGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              chip_select,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_abort
);

  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int EDGE_W = (LEAD_EDGES > 1) ? $clog2(LEAD_EDGES) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [EDGE_W-1:0] LEAD_LAST = EDGE_W'((LEAD_EDGES > 0) ? LEAD_EDGES - 1 : 0);

  // Synchronised pin events
  logic sclk_fall, sclk_sync_unused, sclk_rise_unused;
  logic cs_fall, cs_rise, cs_sync_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk    (clk),
    .reset  (reset),
    .d_i    (sclk),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise_unused),
    .fall_o (sclk_fall)
  );

  sync_edge #(.RST_VAL(CS_IDLE)) u_sync_cs (
    .clk    (clk),
    .reset  (reset),
    .d_i    (chip_select),
    .sync_o (cs_sync_unused),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge #(.RST_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk    (clk),
    .reset  (reset),
    .d_i    (mosi),
    .sync_o (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  // FSM and datapath state
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-2:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_full;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                abort_q, abort_d;

  logic capture;
  logic shift_en;
  logic last_fall;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a final fall coinciding with chip_select release
  // completes the frame and returns straight to IDLE, since no further
  // cs_rise will arrive to leave DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = (LEAD_EDGES > 0) ? LEAD : SHIFT;
      end
      LEAD: begin
        if (cs_rise)                                    state_d = IDLE;
        else if (sclk_fall && (edge_cnt_q == LEAD_LAST)) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_fall)    state_d = cs_rise ? IDLE : DONE;
        else if (cs_rise) state_d = IDLE;
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and strobes; miso is a mux of registered state so it only
  // moves on the clock after a detected sclk fall.
  always_comb begin
    capture   = (state_q == IDLE) && cs_fall;
    tx_ready  = !capture;
    shift_en  = (state_q == SHIFT) && sclk_fall;
    last_fall = shift_en && (bit_cnt_q == BIT_LAST);
    miso      = ((state_q == LEAD) || (state_q == SHIFT)) ? tx_sh_q[DATA_W-1] : 1'b0;
  end

  // Datapath next values. The holding register accepts tx_load even in the
  // capture cycle: the capture reads the old value, so a colliding write
  // lands for the following frame. tx_ready only flags that capture cycle.
  always_comb begin
    hold_d     = hold_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    edge_cnt_d = edge_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    rx_full    = {rx_sh_q, mosi_s};

    if (tx_load) hold_d = tx_data;

    if (capture) begin
      tx_sh_d    = hold_q;
      rx_sh_d    = '0;
      bit_cnt_d  = '0;
      edge_cnt_d = '0;
    end

    if ((state_q == LEAD) && sclk_fall) edge_cnt_d = edge_cnt_q + 1'b1;

    if (shift_en) begin
      rx_sh_d   = rx_full[DATA_W-2:0];
      tx_sh_d   = {tx_sh_q[DATA_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (last_fall) begin
      rx_data_d  = rx_full;
      rx_valid_d = 1'b1;
    end

    abort_d = cs_rise && ((state_q == LEAD) || ((state_q == SHIFT) && !last_fall));
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      edge_cnt_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural 8-bit master drives two
// instances (one with a start pulse, one without) and checks the results.
module tb_spi_slave;

  localparam int HALF = 5;  // sclk half-period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk_p [2];
  logic       cs_p   [2];
  logic       mosi_p [2];
  logic [7:0] tx_data_p [2];
  logic       tx_load_p [2];
  logic       miso_w [2];
  logic       tx_ready_w [2];
  logic [7:0] rx_data_w [2];
  logic       rx_valid_w [2];
  logic       abort_w [2];

  int total = 0;
  int bad   = 0;
  int vcnt [2] = '{0, 0};
  int acnt [2] = '{0, 0};

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8), .LEAD_EDGES(1)) dut_a (
    .clk(clk), .reset(reset), .sclk(sclk_p[0]), .chip_select(cs_p[0]), .mosi(mosi_p[0]),
    .miso(miso_w[0]), .tx_data(tx_data_p[0]), .tx_load(tx_load_p[0]), .tx_ready(tx_ready_w[0]),
    .rx_data(rx_data_w[0]), .rx_valid(rx_valid_w[0]), .frame_abort(abort_w[0])
  );

  spi_slave #(.DATA_W(8), .LEAD_EDGES(0)) dut_b (
    .clk(clk), .reset(reset), .sclk(sclk_p[1]), .chip_select(cs_p[1]), .mosi(mosi_p[1]),
    .miso(miso_w[1]), .tx_data(tx_data_p[1]), .tx_load(tx_load_p[1]), .tx_ready(tx_ready_w[1]),
    .rx_data(rx_data_w[1]), .rx_valid(rx_valid_w[1]), .frame_abort(abort_w[1])
  );

  // Pulse counters for both instances
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rx_valid_w[i]) vcnt[i] <= vcnt[i] + 1;
      if (abort_w[i])    acnt[i] <= acnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int sel, input logic [7:0] v);
    @(negedge clk);
    tx_data_p[sel] = v;
    tx_load_p[sel] = 1'b1;
    @(negedge clk);
    tx_load_p[sel] = 1'b0;
  endtask

  // Master frame: optional start pulses, nbits data bits MSB first, miso
  // sampled as sclk falls; optionally collides a tx_load of cval with the
  // capture cycle; optionally releases chip_select at the end.
  task automatic frame(input int sel, input logic [7:0] mo, input int lead, input int nbits,
                       input bit raise_cs, input bit collide, input logic [7:0] cval,
                       output logic [7:0] mi);
    bit seen;
    mi = 8'h00;
    seen = 1'b0;
    @(negedge clk);
    cs_p[sel] = 1'b0;
    if (collide) begin
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        if (tx_ready_w[sel] == 1'b0) begin
          seen = 1'b1;
          tx_data_p[sel] = cval;
          tx_load_p[sel] = 1'b1;
          @(negedge clk);
          tx_load_p[sel] = 1'b0;
        end
      end
      chk("tx_ready_low_at_capture", {31'd0, seen}, 32'd1);
    end
    wait_neg(HALF);
    for (int l = 0; l < lead; l++) begin
      sclk_p[sel] = 1'b1;
      wait_neg(HALF);
      sclk_p[sel] = 1'b0;
      wait_neg(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi_p[sel] = mo[7-i];
      sclk_p[sel] = 1'b1;
      wait_neg(HALF);
      mi = {mi[6:0], miso_w[sel]};
      sclk_p[sel] = 1'b0;
      wait_neg(HALF);
    end
    if (raise_cs) begin
      cs_p[sel] = 1'b1;
      wait_neg(2 * HALF);
    end
  endtask

  initial begin
    logic [7:0] mi;
    int v0, a0;
    for (int i = 0; i < 2; i++) begin
      sclk_p[i] = 1'b0; cs_p[i] = 1'b1; mosi_p[i] = 1'b0;
      tx_data_p[i] = 8'h00; tx_load_p[i] = 1'b0;
    end
    wait_neg(4);
    reset = 1'b1;
    wait_neg(2);

    // Reset state
    chk("rst_miso", {31'd0, miso_w[0]}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data_w[0]}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid_w[0]}, 32'd0);
    chk("rst_abort", {31'd0, abort_w[0]}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready_w[0]}, 32'd1);
    chk("rst_state", {30'd0, dut_a.state_q}, 32'd0);

    // Loopback: slave sends 0xA5, master sends 0xB5
    load(0, 8'hA5);
    frame(0, 8'hB5, 1, 8, 1'b1, 1'b0, 8'h00, mi);
    chk("loop_rx_data", {24'd0, rx_data_w[0]}, 32'hB5);
    chk("loop_master_rx", {24'd0, mi}, 32'hA5);
    chk("loop_valid_cnt", vcnt[0], 32'd1);
    chk("loop_abort_cnt", acnt[0], 32'd0);

    // Back-to-back frames without reload resend the held byte
    load(0, 8'h3C);
    frame(0, 8'h01, 1, 8, 1'b1, 1'b0, 8'h00, mi);
    chk("b2b1_master_rx", {24'd0, mi}, 32'h3C);
    chk("b2b1_rx_data", {24'd0, rx_data_w[0]}, 32'h01);
    frame(0, 8'h02, 1, 8, 1'b1, 1'b0, 8'h00, mi);
    chk("b2b2_master_rx", {24'd0, mi}, 32'h3C);
    chk("b2b2_rx_data", {24'd0, rx_data_w[0]}, 32'h02);
    chk("b2b_valid_cnt", vcnt[0], 32'd3);

    // Abort after 4 data bits
    frame(0, 8'hF0, 1, 4, 1'b1, 1'b0, 8'h00, mi);
    chk("abort_cnt", acnt[0], 32'd1);
    chk("abort_valid_cnt", vcnt[0], 32'd3);
    chk("abort_rx_data", {24'd0, rx_data_w[0]}, 32'h02);
    chk("abort_state", {30'd0, dut_a.state_q}, 32'd0);
    chk("abort_miso", {31'd0, miso_w[0]}, 32'd0);

    // Load collision in the capture cycle
    load(0, 8'h22);
    frame(0, 8'h44, 1, 8, 1'b1, 1'b1, 8'h11, mi);
    chk("coll_first_master_rx", {24'd0, mi}, 32'h22);
    frame(0, 8'h55, 1, 8, 1'b1, 1'b0, 8'h00, mi);
    chk("coll_next_master_rx", {24'd0, mi}, 32'h11);
    chk("coll_rx_data", {24'd0, rx_data_w[0]}, 32'h55);

    // Reset mid-SHIFT after 3 bits
    v0 = vcnt[0];
    a0 = acnt[0];
    frame(0, 8'hE0, 1, 3, 1'b0, 1'b0, 8'h00, mi);
    chk("pre_rst_state", {30'd0, dut_a.state_q}, 32'd2);
    @(negedge clk);
    reset = 1'b0;
    wait_neg(3);
    chk("mrst_miso", {31'd0, miso_w[0]}, 32'd0);
    chk("mrst_rx_data", {24'd0, rx_data_w[0]}, 32'h00);
    chk("mrst_tx_ready", {31'd0, tx_ready_w[0]}, 32'd1);
    chk("mrst_state", {30'd0, dut_a.state_q}, 32'd0);
    cs_p[0] = 1'b1;
    wait_neg(4);
    reset = 1'b1;
    wait_neg(4);
    chk("mrst_no_valid", vcnt[0], v0);
    chk("mrst_no_abort", acnt[0], a0);
    frame(0, 8'h5A, 1, 8, 1'b1, 1'b0, 8'h00, mi);
    chk("post_rst_rx_data", {24'd0, rx_data_w[0]}, 32'h5A);
    chk("post_rst_master_rx", {24'd0, mi}, 32'h00);
    chk("post_rst_valid_cnt", vcnt[0], v0 + 1);

    // No start pulse (second instance), plus a trailing sclk pulse in DONE
    load(1, 8'hC3);
    frame(1, 8'h96, 0, 8, 1'b0, 1'b0, 8'h00, mi);
    chk("nolead_master_rx", {24'd0, mi}, 32'hC3);
    chk("nolead_rx_data", {24'd0, rx_data_w[1]}, 32'h96);
    mosi_p[1] = 1'b1;
    sclk_p[1] = 1'b1;
    wait_neg(HALF);
    sclk_p[1] = 1'b0;
    wait_neg(HALF);
    chk("done_state", {30'd0, dut_b.state_q}, 32'd3);
    chk("done_miso", {31'd0, miso_w[1]}, 32'd0);
    chk("done_rx_data", {24'd0, rx_data_w[1]}, 32'h96);
    chk("done_valid_cnt", vcnt[1], 32'd1);
    cs_p[1] = 1'b1;
    wait_neg(2 * HALF);
    chk("nolead_abort_cnt", acnt[1], 32'd0);
    chk("nolead_final_state", {30'd0, dut_b.state_q}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
